rhythm_judge: RTL and testbench



---
 rtl/judge_pkg.sv | 17 +
 rtl/rhythm_judge_if.sv | 32 +++
 rtl/judge_channel.sv | 143 ++++++++++++++
 rtl/rhythm_judge.sv | 67 ++++++
 tb/tb_rhythm_judge.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/judge_pkg.sv
// rtl/judge_pkg.sv - result codes and per-channel state encoding for rhythm_judge
package judge_pkg;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_PERFECT = 2'b01,
        RES_GOOD    = 2'b10,
        RES_MISS    = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rhythm_judge_if.sv
// rtl/rhythm_judge_if.sv - note stream, keypad and per-channel result bundle for rhythm_judge
interface rhythm_judge_if #(
    parameter int CHANNELS = 2,
    parameter int SCORE_W  = 20,
    parameter int COMBO_W  = 8
) ();
    logic                          en;
    logic                          tick_1ms;
    logic                          note_start;
    logic [3:0]                    exp_note;
    logic [3:0]                    exp_octave;
    logic [CHANNELS-1:0]           play_valid;
    logic [4*CHANNELS-1:0]         play_note;
    logic [4*CHANNELS-1:0]         play_octave;
    logic [SCORE_W*CHANNELS-1:0]   score;
    logic [COMBO_W*CHANNELS-1:0]   combo;
    logic [COMBO_W*CHANNELS-1:0]   max_combo;
    logic [2*CHANNELS-1:0]         result;
    logic [CHANNELS-1:0]           result_valid;

    modport master (
        output en, tick_1ms, note_start, exp_note, exp_octave,
        output play_valid, play_note, play_octave,
        input  score, combo, max_combo, result, result_valid
    );

    modport slave (
        input  en, tick_1ms, note_start, exp_note, exp_octave,
        input  play_valid, play_note, play_octave,
        output score, combo, max_combo, result, result_valid
    );
endinterface

// File: rtl/judge_channel.sv
// rtl/judge_channel.sv - one player's timing window, grading, score and combo tracking
module judge_channel
    import judge_pkg::*;
#(
    parameter int SCORE_W     = 20,
    parameter int COMBO_W     = 8,
    parameter int PERFECT_MS  = 50,
    parameter int GOOD_MS     = 150,
    parameter int PERFECT_PTS = 10,
    parameter int GOOD_PTS    = 5,
    parameter int COMBO_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               tick_1ms,
    input  logic               note_start,
    input  logic               note_rest,
    input  logic [3:0]         ref_note,
    input  logic [3:0]         ref_octave,
    input  logic               play_valid,
    input  logic [3:0]         play_note,
    input  logic [3:0]         play_octave,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output result_t            result,
    output logic               result_valid
);
    localparam int CNT_W = $clog2(GOOD_MS + 2);
    localparam logic [CNT_W-1:0]   CNT_GOOD = CNT_W'(GOOD_MS);
    localparam logic [CNT_W-1:0]   CNT_PERF = CNT_W'(PERFECT_MS);
    localparam logic [SCORE_W:0]   PERF_ADD = (SCORE_W+1)'(PERFECT_PTS);
    localparam logic [SCORE_W:0]   GOOD_ADD = (SCORE_W+1)'(GOOD_PTS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               pend_match_q, pend_match_d;
    result_t            res_d;
    logic               open_w, rest_w, match_w;
    logic [SCORE_W:0]   bonus_w, sum_w;
    logic [SCORE_W-1:0] score_sat;
    logic [COMBO_W-1:0] combo_inc;

    assign open_w  = note_start && !note_rest;
    assign rest_w  = note_start && note_rest;
    assign match_w = (play_note == ref_note) && (play_octave == ref_octave);

    function automatic result_t grade(input logic m, input logic [CNT_W-1:0] c);
        if (!m)
            return RES_MISS;
        return (c <= CNT_PERF) ? RES_PERFECT : RES_GOOD;
    endfunction

    // A press arriving with a note_start that also kills an open window is parked
    // in pend_q: the old window's MISS owns this cycle, the press is graded next cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_match_d = pend_match_q;
        res_d        = RES_NONE;
        if (en) begin
            case (state_q)
                ST_WAIT: begin
                    if (pend_q)
                        res_d = grade(pend_match_q, '0);
                    else if (open_w)
                        res_d = RES_MISS;
                    else if (!rest_w && cnt_q > CNT_GOOD)
                        res_d = RES_MISS;
                    else if (!rest_w && play_valid)
                        res_d = grade(match_w, cnt_q);
                    else if (!rest_w && tick_1ms)
                        cnt_d = cnt_q + 1'b1;

                    if (open_w) begin
                        state_d      = ST_WAIT;
                        cnt_d        = '0;
                        pend_d       = play_valid;
                        pend_match_d = match_w;
                    end else if (rest_w) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else if (res_d != RES_NONE) begin
                        state_d = ST_DONE;
                        pend_d  = 1'b0;
                    end
                end
                default: begin
                    if (open_w) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                        if (play_valid) begin
                            res_d   = grade(match_w, '0);
                            state_d = ST_DONE;
                        end
                    end else if (rest_w) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bonus_w   = (SCORE_W+1)'(combo >> COMBO_SHIFT);
    assign sum_w     = {1'b0, score} + ((res_d == RES_PERFECT) ? PERF_ADD : GOOD_ADD) + bonus_w;
    assign score_sat = sum_w[SCORE_W] ? '1 : sum_w[SCORE_W-1:0];
    assign combo_inc = (&combo) ? combo : combo + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_match_q <= 1'b0;
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
            result       <= RES_NONE;
            result_valid <= 1'b0;
        end else if (en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_match_q <= pend_match_d;
            result_valid <= (res_d != RES_NONE);
            if (res_d != RES_NONE)
                result <= res_d;
            if (res_d == RES_PERFECT || res_d == RES_GOOD) begin
                score     <= score_sat;
                combo     <= combo_inc;
                max_combo <= (combo_inc > max_combo) ? combo_inc : max_combo;
            end else if (res_d == RES_MISS) begin
                combo <= '0;
            end
        end else begin
            result_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/rhythm_judge.sv
// rtl/rhythm_judge.sv - multi-player note judge: shared expected-note register and per-channel judges
module rhythm_judge
    import judge_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SCORE_W     = 20,
    parameter int COMBO_W     = 8,
    parameter int PERFECT_MS  = 50,
    parameter int GOOD_MS     = 150,
    parameter int PERFECT_PTS = 10,
    parameter int GOOD_PTS    = 5,
    parameter int COMBO_SHIFT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rhythm_judge_if.slave  bus
);
    logic [3:0] note_q, octave_q;
    logic [3:0] ref_note, ref_octave;
    logic       note_open, note_rest;

    assign note_rest = (bus.exp_note == 4'd0);
    assign note_open = bus.note_start && !note_rest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            note_q   <= 4'd0;
            octave_q <= 4'd0;
        end else if (bus.en && note_open) begin
            note_q   <= bus.exp_note;
            octave_q <= bus.exp_octave;
        end
    end

    // Presses in the same cycle as a new note compare against the incoming note.
    assign ref_note   = note_open ? bus.exp_note   : note_q;
    assign ref_octave = note_open ? bus.exp_octave : octave_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SCORE_W-1:0] score_w;
        logic [COMBO_W-1:0] combo_w, max_w;
        result_t            res_w;
        logic               rv_w;

        judge_channel #(
            .SCORE_W(SCORE_W), .COMBO_W(COMBO_W),
            .PERFECT_MS(PERFECT_MS), .GOOD_MS(GOOD_MS),
            .PERFECT_PTS(PERFECT_PTS), .GOOD_PTS(GOOD_PTS),
            .COMBO_SHIFT(COMBO_SHIFT)
        ) u_channel (
            .clk(clk), .rst_n(rst_n), .en(bus.en), .tick_1ms(bus.tick_1ms),
            .note_start(bus.note_start), .note_rest(note_rest),
            .ref_note(ref_note), .ref_octave(ref_octave),
            .play_valid(bus.play_valid[i]),
            .play_note(bus.play_note[4*i +: 4]),
            .play_octave(bus.play_octave[4*i +: 4]),
            .score(score_w), .combo(combo_w), .max_combo(max_w),
            .result(res_w), .result_valid(rv_w)
        );

        assign bus.score[SCORE_W*i +: SCORE_W]     = score_w;
        assign bus.combo[COMBO_W*i +: COMBO_W]     = combo_w;
        assign bus.max_combo[COMBO_W*i +: COMBO_W] = max_w;
        assign bus.result[2*i +: 2]                = res_w;
        assign bus.result_valid[i]                 = rv_w;
    end
endmodule

// File: tb/tb_rhythm_judge.sv
// tb/tb_rhythm_judge.sv - table, directed and random checks of rhythm_judge against a window model
module tb_rhythm_judge;
    import judge_pkg::*;

    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rv_seen;

    rhythm_judge_if #(.CHANNELS(CH), .SCORE_W(20), .COMBO_W(8)) bus ();
    rhythm_judge_if #(.CHANNELS(CH), .SCORE_W(6),  .COMBO_W(8)) bus_s ();

    assign bus_s.en          = bus.en;
    assign bus_s.tick_1ms    = bus.tick_1ms;
    assign bus_s.note_start  = bus.note_start;
    assign bus_s.exp_note    = bus.exp_note;
    assign bus_s.exp_octave  = bus.exp_octave;
    assign bus_s.play_valid  = bus.play_valid;
    assign bus_s.play_note   = bus.play_note;
    assign bus_s.play_octave = bus.play_octave;

    rhythm_judge #(.CHANNELS(CH)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    rhythm_judge #(.CHANNELS(CH), .SCORE_W(6)) u_small (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    always #5 clk = ~clk;

    // Reference model: a window is either open or not; DONE and IDLE are indistinguishable here.
    int m_score[CH], m_score_s[CH], m_combo[CH], m_max[CH], m_res[CH], m_ms[CH], m_pgrade[CH];
    bit m_rv[CH], m_win[CH], m_pend[CH];
    int m_note, m_oct;

    function automatic int grade(bit m, int ms);
        if (!m) return 3;
        return (ms <= 50) ? 1 : 2;
    endfunction

    task automatic apply_verdict(int c, int v);
        int add;
        m_rv[c] = (v != 0);
        if (v != 0) m_res[c] = v;
        if (v == 1 || v == 2) begin
            add = ((v == 1) ? 10 : 5) + (m_combo[c] >> 4);
            m_score[c]   = (m_score[c] + add > 1048575) ? 1048575 : m_score[c] + add;
            m_score_s[c] = (m_score_s[c] + add > 63) ? 63 : m_score_s[c] + add;
            if (m_combo[c] < 255) m_combo[c]++;
            if (m_combo[c] > m_max[c]) m_max[c] = m_combo[c];
        end else if (v == 3) begin
            m_combo[c] = 0;
        end
    endtask

    task automatic model_step();
        bit open, rest, pv, mt;
        int v;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_score[c] = 0; m_score_s[c] = 0; m_combo[c] = 0; m_max[c] = 0; m_res[c] = 0;
                m_ms[c] = 0; m_pgrade[c] = 0; m_rv[c] = 0; m_win[c] = 0; m_pend[c] = 0;
            end
            m_note = 0; m_oct = 0;
            return;
        end
        if (!bus.en) begin
            for (int c = 0; c < CH; c++) m_rv[c] = 0;
            return;
        end
        open = bus.note_start && (bus.exp_note != 0);
        rest = bus.note_start && (bus.exp_note == 0);
        if (open) begin m_note = int'(bus.exp_note); m_oct = int'(bus.exp_octave); end
        for (int c = 0; c < CH; c++) begin
            pv = bus.play_valid[c];
            mt = (int'(bus.play_note[4*c +: 4]) == m_note) && (int'(bus.play_octave[4*c +: 4]) == m_oct);
            v = 0;
            if (m_win[c]) begin
                if (m_pend[c])                   v = m_pgrade[c];
                else if (open)                   v = 3;
                else if (!rest && m_ms[c] > 150) v = 3;
                else if (!rest && pv)            v = grade(mt, m_ms[c]);
                else if (!rest && bus.tick_1ms)  m_ms[c]++;
                if (open) begin
                    m_ms[c] = 0; m_pend[c] = pv; m_pgrade[c] = mt ? 1 : 3;
                end else if (rest || v != 0) begin
                    m_win[c] = 0; m_pend[c] = 0;
                end
            end else if (open) begin
                m_ms[c] = 0; m_pend[c] = 0;
                if (pv) v = grade(mt, 0);
                else    m_win[c] = 1;
            end
            apply_verdict(c, v);
        end
    endtask

    task automatic chk(string name, int c, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %0d expected %0d", name, c, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        for (int c = 0; c < CH; c++) begin
            chk("score", c, 32'(bus.score[20*c +: 20]), m_score[c]);
            chk("score_sat6", c, 32'(bus_s.score[6*c +: 6]), m_score_s[c]);
            chk("combo", c, 32'(bus.combo[8*c +: 8]), m_combo[c]);
            chk("max_combo", c, 32'(bus.max_combo[8*c +: 8]), m_max[c]);
            chk("result", c, 32'(bus.result[2*c +: 2]), m_res[c]);
            chk("result_valid", c, 32'(bus.result_valid[c]), 32'(m_rv[c]));
        end
        if (|bus.result_valid) rv_seen = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.tick_1ms = 0; bus.note_start = 0; bus.play_valid = '0;
    endtask

    task automatic note(int n, int o);
        bus.note_start = 1; bus.exp_note = 4'(n); bus.exp_octave = 4'(o);
        cycle();
        bus.note_start = 0;
    endtask

    task automatic tick_n(int n);
        for (int k = 0; k < n; k++) begin
            bus.tick_1ms = 1; cycle();
        end
        bus.tick_1ms = 0;
    endtask

    task automatic press(int c, int n, int o);
        bus.play_valid[c] = 1; bus.play_note[4*c +: 4] = 4'(n); bus.play_octave[4*c +: 4] = 4'(o);
        cycle();
        bus.play_valid = '0;
    endtask

    typedef struct {
        int c; int ticks; bit do_press; int pn; int po;
        int res; int score; int combo;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        tbl[0] = '{1, 100, 1, 5, 4, 2, 5, 1};
        tbl[1] = '{0, 30,  1, 5, 4, 1, 10, 1};
        tbl[2] = '{0, 50,  1, 5, 4, 1, 20, 2};
        tbl[3] = '{0, 51,  1, 5, 4, 2, 25, 3};
        tbl[4] = '{0, 150, 1, 5, 4, 2, 30, 4};
        tbl[5] = '{0, 0,   1, 6, 4, 3, 30, 0};
        tbl[6] = '{0, 10,  1, 5, 3, 3, 30, 0};
        tbl[7] = '{0, 151, 0, 0, 0, 3, 30, 0};
        tbl[8] = '{0, 0,   1, 5, 4, 1, 40, 1};

        bus.en = 1; bus.exp_note = 0; bus.exp_octave = 0;
        bus.play_note = '0; bus.play_octave = '0;
        idle_inputs();
        rst_n = 0; cycle(); cycle();
        chk("reset_score", 0, 32'(bus.score), 0);
        chk("reset_result_valid", 0, 32'(bus.result_valid), 0);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            note(5, 4);
            tick_n(tbl[i].ticks);
            if (tbl[i].do_press) press(tbl[i].c, tbl[i].pn, tbl[i].po);
            seen = bus.result_valid[tbl[i].c];
            for (int w = 0; w < 4 && !seen; w++) begin
                cycle(); seen = bus.result_valid[tbl[i].c];
            end
            chk("tbl_seen", tbl[i].c, 32'(seen), 1);
            chk("tbl_result", tbl[i].c, 32'(bus.result[2*tbl[i].c +: 2]), tbl[i].res);
            chk("tbl_score", tbl[i].c, 32'(bus.score[20*tbl[i].c +: 20]), tbl[i].score);
            chk("tbl_combo", tbl[i].c, 32'(bus.combo[8*tbl[i].c +: 8]), tbl[i].combo);
        end

        // 20 PERFECTs from a clean start: combo bonus kicks in at the 17th hit
        rst_n = 0; cycle(); rst_n = 1;
        for (int k = 1; k <= 20; k++) begin
            note(5, 4);
            press(0, 5, 4);
            if (k == 17) chk("hit17_score", 0, 32'(bus.score[19:0]), 171);
        end
        chk("streak_score", 0, 32'(bus.score[19:0]), 204);
        chk("streak_max", 0, 32'(bus.max_combo[7:0]), 20);
        chk("streak_sat6", 0, 32'(bus_s.score[5:0]), 63);
        note(5, 4);
        press(0, 6, 4);
        chk("wrong_result", 0, 32'(bus.result[1:0]), 3);
        chk("wrong_combo", 0, 32'(bus.combo[7:0]), 0);
        chk("wrong_max", 0, 32'(bus.max_combo[7:0]), 20);

        // new note with a press in the same cycle while the old window is open
        note(5, 4);
        tick_n(5);
        bus.note_start = 1; bus.exp_note = 5; bus.exp_octave = 4;
        bus.play_valid[0] = 1; bus.play_note[3:0] = 5; bus.play_octave[3:0] = 4;
        cycle();
        idle_inputs();
        chk("overlap_miss_valid", 0, 32'(bus.result_valid[0]), 1);
        chk("overlap_miss", 0, 32'(bus.result[1:0]), 3);
        cycle();
        chk("overlap_hit_valid", 0, 32'(bus.result_valid[0]), 1);
        chk("overlap_hit", 0, 32'(bus.result[1:0]), 1);

        // rest closes the window silently; later ticks must not time it out
        note(5, 4);
        tick_n(20);
        rv_seen = 0;
        note(0, 0);
        tick_n(200);
        chk("rest_silent", 0, 32'(rv_seen), 0);

        // en low freezes the open window and ignores every input pulse
        note(5, 4);
        tick_n(10);
        bus.en = 0; rv_seen = 0;
        tick_n(200);
        note(7, 2);
        press(0, 7, 2);
        chk("en_low_silent", 0, 32'(rv_seen), 0);
        bus.en = 1;
        press(0, 5, 4);
        chk("en_resume_result", 0, 32'(bus.result[1:0]), 1);

        // reset mid-window drops the window with no MISS
        note(5, 4);
        tick_n(40);
        rst_n = 0; cycle(); rst_n = 1;
        chk("rst_combo", 0, 32'(bus.combo), 0);
        chk("rst_result", 0, 32'(bus.result), 0);
        rv_seen = 0;
        tick_n(160);
        chk("rst_no_miss", 0, 32'(rv_seen), 0);

        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 499) != 0);
            bus.en         = ($urandom_range(0, 19) != 0);
            bus.tick_1ms   = ($urandom_range(0, 3) != 0);
            bus.note_start = ($urandom_range(0, 79) == 0);
            bus.exp_note   = 4'($urandom_range(0, 3));
            bus.exp_octave = 4'($urandom_range(0, 1));
            for (int c = 0; c < CH; c++) begin
                bus.play_valid[c]          = ($urandom_range(0, 49) == 0);
                bus.play_note[4*c +: 4]    = 4'($urandom_range(1, 3));
                bus.play_octave[4*c +: 4]  = 4'($urandom_range(0, 1));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
